// File: rtl/text_mem_arbiter.sv
// Single-port text memory arbiter: renderer reads, hardware clear engine, CPU port.
// Fixed priority per cycle: video > clear > CPU. Read responses are tracked by a registered owner tag.
module text_mem_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int CELLS = 2000,
  parameter logic [DATA_W-1:0] CLEAR_VAL = 16'h0020
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_valid,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_grant;
  logic              vid_rd_q;
  logic              cpu_rd_q;
  logic [DATA_W-1:0] rdata_hold;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (clr_start) state_nxt = CLEAR;
      CLEAR: if (clr_grant && clr_cnt == LAST_CELL) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // CPU handshake: a transfer happens on a cycle with cpu_valid && cpu_ready; the CPU holds
  // cpu_we/cpu_addr/cpu_wdata stable until then. Combinational outputs are forced idle in reset.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_ready = 1'b0;
    clr_grant = 1'b0;
    clr_busy  = (state == CLEAR);
    if (resetn) begin
      if (vid_req) begin
        mem_en   = 1'b1;
        mem_addr = vid_addr;
      end else if (state == CLEAR) begin
        clr_grant = 1'b1;
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = clr_cnt;
        mem_wdata = CLEAR_VAL;
      end else if (cpu_valid) begin
        cpu_ready = 1'b1;
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clr_cnt <= '0;
    end else if (clr_grant) begin
      clr_cnt <= (clr_cnt == LAST_CELL) ? '0 : clr_cnt + 1'b1;
    end
  end

  // Owner tag of last cycle's read; mem_rdata belongs to whoever issued it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vid_rd_q   <= 1'b0;
      cpu_rd_q   <= 1'b0;
      rdata_hold <= '0;
    end else begin
      vid_rd_q <= vid_req;
      cpu_rd_q <= cpu_ready && !cpu_we;
      if (cpu_rd_q) rdata_hold <= mem_rdata;
    end
  end

  assign vid_valid  = vid_rd_q;
  assign vid_data   = mem_rdata;
  assign cpu_rvalid = cpu_rd_q;
  assign cpu_rdata  = cpu_rd_q ? mem_rdata : rdata_hold;

endmodule

// File: tb/tb_text_mem_arbiter.sv
// Bench for text_mem_arbiter: behavioural BRAM, grant vector table, and clear/contention/reset sequences.
module tb_text_mem_arbiter;

  logic        clk;
  logic        resetn;
  logic        vid_req;
  logic [10:0] vid_addr;
  logic        vid_valid;
  logic [15:0] vid_data;
  logic        cpu_valid;
  logic        cpu_we;
  logic [10:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        clr_start;
  logic        clr_busy;
  logic        mem_en;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  text_mem_arbiter dut (
    .clk(clk), .resetn(resetn),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_data(vid_data),
    .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [2048];
  int          wr_cnt [2048];
  int          total_we;
  logic [15:0] exp_q [$];
  int          n_vec;
  int          n_err;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        wr_cnt[mem_addr] <= wr_cnt[mem_addr] + 1;
        total_we <= total_we + 1;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected CPU read data is captured from the memory model at the accepting edge.
  always @(posedge clk) begin
    if (resetn && cpu_valid && cpu_ready && !cpu_we) exp_q.push_back(mem[cpu_addr]);
  end

  always @(negedge clk) begin
    if (resetn && cpu_rvalid) begin
      if (exp_q.size() == 0) chk("cpu_rvalid_unexpected", 32'd1, 32'd0);
      else                   chk("cpu_rdata_q", 32'(cpu_rdata), 32'(exp_q.pop_front()));
    end
  end

  typedef struct {
    logic        vreq;
    logic [10:0] vaddr;
    logic        cval;
    logic        cwe;
    logic [10:0] caddr;
    logic [15:0] cwd;
    logic        en;
    logic        we;
    logic [10:0] maddr;
    logic [15:0] mwd;
    logic        rdy;
  } vec_t;

  vec_t vecs [7];

  task automatic idle_inputs();
    vid_req = 1'b0; vid_addr = '0; cpu_valid = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; clr_start = 1'b0;
  endtask

  task automatic fill_mem(input logic [15:0] v);
    for (int i = 0; i < 2048; i++) mem[i] = v;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_n;
    int bad;
    int vid_n;
    int we_at;
    int we_before;
    logic prev_vid;

    n_vec = 0; n_err = 0; total_we = 0;
    mem_rdata = '0;
    resetn = 1'b0;
    idle_inputs();
    for (int i = 0; i < 2048; i++) begin mem[i] = '0; wr_cnt[i] = 0; end

    vecs[0] = '{1'b0, 11'd0,    1'b0, 1'b0, 11'd0,   16'h0000, 1'b0, 1'b0, 11'd0,    16'h0000, 1'b0};
    vecs[1] = '{1'b1, 11'd3,    1'b0, 1'b0, 11'd0,   16'h0000, 1'b1, 1'b0, 11'd3,    16'h0000, 1'b0};
    vecs[2] = '{1'b0, 11'd0,    1'b1, 1'b0, 11'd10,  16'h0000, 1'b1, 1'b0, 11'd10,   16'h0000, 1'b1};
    vecs[3] = '{1'b0, 11'd0,    1'b1, 1'b1, 11'd11,  16'h5555, 1'b1, 1'b1, 11'd11,   16'h5555, 1'b1};
    vecs[4] = '{1'b1, 11'd20,   1'b1, 1'b1, 11'd21,  16'h7777, 1'b1, 1'b0, 11'd20,   16'h0000, 1'b0};
    vecs[5] = '{1'b1, 11'd2047, 1'b1, 1'b0, 11'd0,   16'h0000, 1'b1, 1'b0, 11'd2047, 16'h0000, 1'b0};
    vecs[6] = '{1'b0, 11'd0,    1'b1, 1'b1, 11'd2047,16'hAAAA, 1'b1, 1'b1, 11'd2047, 16'hAAAA, 1'b1};

    // Reset held with inputs toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vid_req = 1'($urandom_range(0, 1)); vid_addr = 11'($urandom_range(0, 2047));
      cpu_valid = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = 11'($urandom_range(0, 2047)); cpu_wdata = 16'($urandom);
      clr_start = 1'($urandom_range(0, 1));
      #1;
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
      chk("rst_outputs", {28'd0, vid_valid, cpu_rvalid, clr_busy, mem_we}, 32'd0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    end
    chk("rst_no_write", 32'(total_we), 32'd0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Grant table, all in IDLE
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      vid_req = vecs[i].vreq; vid_addr = vecs[i].vaddr;
      cpu_valid = vecs[i].cval; cpu_we = vecs[i].cwe;
      cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwd;
      #1;
      chk($sformatf("vec%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].en));
      chk($sformatf("vec%0d_cpu_ready", i), 32'(cpu_ready), 32'(vecs[i].rdy));
      if (vecs[i].en) begin
        chk($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].we));
        chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].maddr));
        if (vecs[i].we) chk($sformatf("vec%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].mwd));
      end
    end
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);

    // CPU write then read at address 5
    @(negedge clk);
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 11'd5; cpu_wdata = 16'h4148;
    #1 chk("wr5_ready", 32'(cpu_ready), 32'd1);
    @(negedge clk);
    cpu_we = 1'b0;
    #1 chk("rd5_ready", 32'(cpu_ready), 32'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rd5_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("rd5_rdata", 32'(cpu_rdata), 32'h4148);
    @(negedge clk);
    #1;
    chk("rd5_rvalid_pulse", 32'(cpu_rvalid), 32'd0);
    chk("rd5_rdata_held", 32'(cpu_rdata), 32'h4148);

    // Video and CPU write in the same cycle
    @(negedge clk);
    mem[7] = 16'h1234; mem[9] = 16'h0000; wr_cnt[9] = 0;
    vid_req = 1'b1; vid_addr = 11'd7;
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 11'd9; cpu_wdata = 16'hABCD;
    #1;
    chk("cont_ready_lo", 32'(cpu_ready), 32'd0);
    chk("cont_mem_addr", 32'(mem_addr), 32'd7);
    @(negedge clk);
    vid_req = 1'b0;
    #1;
    chk("cont_vid_valid", 32'(vid_valid), 32'd1);
    chk("cont_vid_data", 32'(vid_data), 32'h1234);
    chk("cont_ready_hi", 32'(cpu_ready), 32'd1);
    @(negedge clk);
    idle_inputs();
    #1 chk("cont_vid_valid_drop", 32'(vid_valid), 32'd0);
    @(negedge clk);
    chk("cont_addr9_once", 32'(wr_cnt[9]), 32'd1);
    chk("cont_addr9_data", 32'(mem[9]), 32'hABCD);

    // Clear without video, started alongside a CPU write
    fill_mem(16'hFFFF);
    @(negedge clk);
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 11'd2010; cpu_wdata = 16'h1111;
    clr_start = 1'b1;
    #1;
    chk("clr_cpu_first_ready", 32'(cpu_ready), 32'd1);
    chk("clr_cpu_first_addr", 32'(mem_addr), 32'd2010);
    chk("clr_busy_not_yet", 32'(clr_busy), 32'd0);
    @(negedge clk);
    clr_start = 1'b0; cpu_we = 1'b0; cpu_addr = 11'd0;
    #1;
    chk("clr_busy_rise", 32'(clr_busy), 32'd1);
    busy_n = 1; bad = 0;
    for (int c = 0; c < 5000; c++) begin
      if (cpu_ready) bad++;
      if (c == 1000) begin clr_start = 1'b1; end
      if (c == 1001) begin clr_start = 1'b0; end
      @(negedge clk);
      #1;
      if (!clr_busy) break;
      busy_n++;
    end
    chk("clr_busy_cycles", 32'(busy_n), 32'd2000);
    chk("clr_cpu_starved", 32'(bad), 32'd0);
    chk("clr_cpu_ready_after", 32'(cpu_ready), 32'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("clr_read0_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("clr_read0_rdata", 32'(cpu_rdata), 32'h0020);
    bad = 0;
    for (int i = 0; i < 2000; i++) if (mem[i] !== 16'h0020) bad++;
    chk("clr_cells_cleared", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 2000; i < 2048; i++) if (mem[i] !== ((i == 2010) ? 16'h1111 : 16'hFFFF)) bad++;
    chk("clr_cells_beyond", 32'(bad), 32'd0);

    // Clear with video on every other cycle
    fill_mem(16'hFFFF);
    pulse_clear();
    busy_n = 0; vid_n = 0; bad = 0;
    while (clr_busy && busy_n < 10000) begin
      vid_req = (busy_n % 2 == 1);
      vid_addr = 11'(busy_n);
      if (vid_req) vid_n++;
      prev_vid = vid_req;
      @(negedge clk);
      #1;
      if (vid_valid !== prev_vid) bad++;
      busy_n++;
    end
    vid_req = 1'b0;
    chk("vclr_busy_cycles", 32'(busy_n), 32'd3999);
    chk("vclr_vid_count", 32'(vid_n), 32'd1999);
    chk("vclr_vid_valid", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < 2000; i++) if (mem[i] !== 16'h0020) bad++;
    chk("vclr_cells_cleared", 32'(bad), 32'd0);

    // Reset after 100 clear writes
    fill_mem(16'hFFFF);
    @(negedge clk);
    we_before = total_we;
    pulse_clear();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
    end
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(clr_busy), 32'd0);
    chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
    we_at = total_we;
    chk("mid_rst_writes_done", 32'(we_at - we_before), 32'd100);
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_rst_no_more_we", 32'(total_we), 32'(we_at));
    chk("mid_rst_no_resume", 32'(clr_busy), 32'd0);
    bad = 0;
    for (int i = 0; i < 100; i++) if (mem[i] !== 16'h0020) bad++;
    for (int i = 100; i < 2000; i++) if (mem[i] !== 16'hFFFF) bad++;
    chk("mid_rst_cells", 32'(bad), 32'd0);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/text_mem_arbiter.md
Name: text_mem_arbiter

Overview:
Owns the single-port text character memory (synchronous BRAM, 1-cycle read latency) in the SoC top. Shares it between three requesters:
- HDMI text renderer read port: hard real-time, highest priority.
- Hardware clear engine: fills every cell with a blank.
- CPU bus port: valid/ready handshake, lowest priority.
Lets firmware clear the screen in CELLS cycles instead of a software loop.

Parameters:
ADDR_W, 11, cell address width
DATA_W, 16, cell width (char code plus attribute)
CELLS, 2000, number of cells cleared (addresses 0..CELLS-1); CELLS <= 2**ADDR_W
CLEAR_VAL, 16'h0020, value written by the clear engine

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
vid_req  in  1  renderer read request; always granted the same cycle
vid_addr  in  ADDR_W  renderer read address
vid_valid  out  1  vid_data valid; registered, 1 cycle after vid_req
vid_data  out  DATA_W  renderer read data (mem_rdata passthrough)
cpu_valid  in  1  CPU request
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ready  out  1  CPU request accepted this cycle
cpu_rvalid  out  1  one-cycle pulse, cpu_rdata updated
cpu_rdata  out  DATA_W  CPU read data, held until the next CPU read completes
clr_start  in  1  one-cycle pulse, starts a clear
clr_busy  out  1  clear in progress
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after a read with mem_en

Behaviour:
- Clock and reset: single clock domain; all flops reset asynchronously on resetn low.
- Reset values:
  - Outputs: vid_valid, cpu_rvalid, cpu_rdata, clr_busy all 0.
  - State: state=IDLE, clr_cnt=0.
  - Memory outputs: mem_en, mem_we, mem_addr, mem_wdata all 0.
- States: IDLE, CLEAR. clr_busy = (state==CLEAR).
- Per-cycle grant, fixed priority, evaluated combinationally:
  1. vid_req: mem_en=1, mem_we=0, mem_addr=vid_addr.
  2. Else if CLEAR: mem_en=1, mem_we=1, mem_addr=clr_cnt, mem_wdata=CLEAR_VAL.
  3. Else if IDLE and cpu_valid: mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  4. Else: mem_en=0.
- cpu_ready = cpu_valid && !vid_req && state==IDLE.
- CPU handshake:
  - Transfer occurs when cpu_valid && cpu_ready.
  - The CPU holds cpu_valid, cpu_we, cpu_addr and cpu_wdata stable until the transfer.
  - The CPU may be starved indefinitely. Renderer duty below 100% (blanking) is guaranteed at integration.
- Read tracking:
  - A registered owner tag records who issued last cycle's read.
  - Video owner: vid_valid=1.
  - CPU owner: cpu_rvalid=1 and cpu_rdata <= mem_rdata, in the cycle after the read grant (latency 1).
  - Writes produce no response.
- Clear engine:
  - IDLE + clr_start: next cycle state=CLEAR, clr_cnt=0.
  - clr_start while in CLEAR is ignored.
  - clr_cnt increments only on cycles where the clear write is granted (no vid_req).
  - When the write to CELLS-1 is granted: state <= IDLE, clr_cnt <= 0, clr_busy falls the next cycle.
  - Clear duration = CELLS + (number of vid_req cycles during CLEAR).
- Simultaneous events:
  - clr_start and cpu_valid in the same IDLE cycle with no vid_req: the CPU is granted that cycle; the clear begins next cycle.
  - vid_req during CLEAR returns current memory contents, partially cleared; this is permitted.
- Reset mid-clear:
  - Immediately state=IDLE and clr_busy=0.
  - No write is issued afterwards; cells already written stay cleared, the rest are unchanged.
  - The clear does not resume after reset.
- clr_cnt width: ADDR_W bits, no wrap, since CELLS <= 2**ADDR_W.

Test Plan:
1. Reset: hold resetn=0 with all inputs toggling -> vid_valid, cpu_ready, cpu_rvalid, clr_busy, mem_en, cpu_rdata all 0; no memory write.
2. CPU write then read: write 16'h4148 at addr 5, read addr 5, no vid_req -> cpu_ready=1 on each request cycle; cpu_rvalid pulses 1 cycle after the read grant; cpu_rdata=16'h4148.
3. Contention: vid_req on addr 7 (holding 16'h1234) asserted the same cycle as a CPU write to addr 9:
   - cpu_ready=0 that cycle and 1 the next.
   - vid_valid=1 with vid_data=16'h1234.
   - addr 9 written exactly once.
4. Clear, no video: fill memory with 16'hFFFF, pulse clr_start -> clr_busy high exactly 2000 cycles; cpu_ready=0 throughout; all cells 0..1999 = 16'h0020; cells 2000..2047 unchanged.
5. Clear with vid_req every other cycle -> clr_busy high 3999 cycles; every video read returns vid_valid the next cycle; all 2000 cells cleared.
6. Reset at clr_cnt=100: assert resetn=0 -> clr_busy=0 immediately; cells 0..99 = 16'h0020; cells 100..1999 = 16'hFFFF; no further mem_we.
